// File: rtl/regfile_wb.sv
// regfile_wb: general-purpose register file fed by the write-back stage.
// Register 0 always reads as zero. A same-cycle write bypasses into both
// read ports. After reset a clear engine zeroes registers 1..NUM_REGS-1,
// one per cycle, before the file accepts writes.
module regfile_wb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic              init_busy
);

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clrIdx_q, clrIdx_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];

   logic              arrayWe;
   logic [ADDR_W-1:0] arrayAddr;
   logic [DATA_W-1:0] arrayData;

   // State and sweep-index registers; reset restarts the sweep at register 1
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= CLEAR;
         clrIdx_q <= FIRST_IDX;
      end else begin
         state_q  <= state_d;
         clrIdx_q <= clrIdx_d;
      end
   end

   // Next-state logic and arbitration of the single array write port
   always_comb begin
      state_d   = state_q;
      clrIdx_d  = clrIdx_q;
      arrayWe   = 1'b0;
      arrayAddr = waddr;
      arrayData = wdata;
      case (state_q)
         CLEAR: begin
            arrayWe   = 1'b1;
            arrayAddr = clrIdx_q;
            arrayData = '0;
            clrIdx_d  = clrIdx_q + FIRST_IDX;
            if (clrIdx_q == LAST_IDX) begin
               state_d = READY;
            end
         end
         READY: begin
            arrayWe = we && (waddr != '0);
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   // Storage array; it has no reset of its own, zeroing comes from the sweep
   always_ff @(posedge clk) begin
      if (!rst && arrayWe) begin
         regs_q[arrayAddr] <= arrayData;
      end
   end

   // Read port 1: masked while busy/disabled, r0 is zero, then bypass, then array
   always_comb begin
      rdata1 = '0;
      if (rst || (state_q == CLEAR)) begin
         rdata1 = '0;
      end else if (!re1) begin
         rdata1 = '0;
      end else if (raddr1 == '0) begin
         rdata1 = '0;
      end else if (we && (waddr == raddr1)) begin
         rdata1 = wdata;
      end else begin
         rdata1 = regs_q[raddr1];
      end
   end

   // Read port 2: same priority as port 1, fully independent of it
   always_comb begin
      rdata2 = '0;
      if (rst || (state_q == CLEAR)) begin
         rdata2 = '0;
      end else if (!re2) begin
         rdata2 = '0;
      end else if (raddr2 == '0) begin
         rdata2 = '0;
      end else if (we && (waddr == raddr2)) begin
         rdata2 = wdata;
      end else begin
         rdata2 = regs_q[raddr2];
      end
   end

   assign init_busy = rst || (state_q == CLEAR);

endmodule
